darkfetch_ctrl: RTL and testbench
=================================

Name: darkfetch_ctrl

Overview:
- Fetch sequencer that owns the darkpc program-counter unit.
- Boots darkpc, strobes its en, and supplies nxpc (sequential pc+4, branch/jump redirect, or trap vector).
- Runs the instruction-memory request/ack handshake and presents fetched instructions to decode over a valid/ready handshake.
- Sits between darkpc, the instruction bus and the decode stage.

Parameters:
TRAP_VEC, 32'h0000_0000, target PC for misaligned-redirect trap (used only with MISALIGN_TRAP_EN)

Ports:
clk  in  1  clock; all state on rising edge
res  in  1  reset, asynchronous assert, active-low (0 = reset)
pc_res  out  1  to darkpc res (active-high, sync)
pc_en  out  1  to darkpc en
pc_nxpc  out  32  to darkpc nxpc
pc_in  in  32  from darkpc pc
pc_valid  in  1  from darkpc valid (one-cycle pulse)
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  32  fetched word
inst_valid  out  1  instruction to decode valid
inst  out  32  instruction word
inst_pc  out  32  address of inst
inst_ready  in  1  decode accepts
redir  in  1  redirect request from execute
redir_pc  in  32  redirect target
halt  in  1  inhibits new pc_en issue
misalign  out  1  one-cycle trap pulse (0 without MISALIGN_TRAP_EN)

Behaviour:
- res=0, asynchronous:
  - state=BOOT.
  - pc_res=1.
  - pc_en, imem_req, inst_valid, misalign = 0.
  - imem_addr, inst, inst_pc, pc_nxpc, internal fpc/nxt = 0.
  - pend and kill flags cleared.
- States: BOOT, START, ISSUE, WPC, WMEM, OUT.
- BOOT: pc_res=1 for exactly the first clock after reset release -> START.
- START: pc_res=0, pc_en=1 (darkpc loads its reset_pc) -> WPC.
- ISSUE:
  - halt=1: pc_en=0, stay.
  - halt=0: pc_en=1, pc_nxpc=nxt -> WPC.
  - redir in this cycle: nxt<=redir_pc; if pc_en is asserted in the same cycle, pc_nxpc=redir_pc (bypass).
- WPC: wait pc_valid.
  - On pc_valid with pend=0: fpc<=pc_in, imem_req<=1, imem_addr<=pc_in -> WMEM.
  - On pc_valid with pend=1: nxt<=pend_pc, clear pend -> ISSUE.
  - pc_valid arriving in the same cycle as redir is treated as pend=1.
- WMEM:
  - imem_req and imem_addr held stable until imem_ack. A request is never withdrawn.
  - On ack with kill=0: inst<=imem_data, inst_pc<=fpc, inst_valid<=1, imem_req<=0 -> OUT.
  - On ack with kill=1: data discarded, nxt<=pend_pc, clear kill and pend -> ISSUE.
- OUT: inst, inst_pc and inst_valid held until handshake.
  - inst_valid&inst_ready, no redir: inst_valid<=0, nxt<=fpc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0) -> ISSUE.
  - redir (with or without ready): inst_valid<=0, nxt<=redir_pc -> ISSUE. Redirect wins; the word counts as consumed.
- Redirect in WPC or WMEM: pend<=1, pend_pc<=redir_pc; in WMEM also kill<=1. A later redir overwrites pend_pc (youngest wins).
- Redirect in BOOT or START: ignored.
- pc_en is never asserted in a cycle where pc_valid=1, because darkpc ignores en in its EXEC cycle.
- Latency, no stalls: pc_en -> pc_valid 1 cycle -> imem_req next cycle; ack -> inst_valid next cycle; handshake -> next pc_en 1 cycle later.
- At most one outstanding imem request and one buffered instruction.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Any redirect target with redir_pc[1:0]!=0 replaces the target with TRAP_VEC.
  - misalign pulses for 1 cycle in the cycle after redir is sampled.
- Undefined: redir_pc[1:0] forced to 2'b00 when captured; misalign tied 0.

Test Plan:
- Reset release, imem_ack 1 cycle after each req, inst_ready=1 (darkpc reset_pc=0) -> pc_res 1 cycle; inst_pc sequence 0,4,8,12; each inst equals the imem_data returned for that address.
- inst_ready=0 for 5 cycles with inst_valid=1 -> inst and inst_pc stable, no pc_en, no imem_req until ready.
- redir=1, redir_pc=0x100 while in WMEM for address 0x8, ack 3 cycles later -> data for 0x8 never shows inst_valid; next imem_addr=0x100.
- redir 0x200 then redir 0x300 in consecutive WPC cycles -> next fetch at 0x300 only.
- halt=1 for 4 cycles in ISSUE -> pc_en held 0; on release pc_en=1 with pc_nxpc=fpc+4.
- MISALIGN_TRAP_EN defined, TRAP_VEC=0x80, redir_pc=0x102 -> misalign 1-cycle pulse, next imem_addr=0x80. Undefined -> next imem_addr=0x100.

Source files
------------

// File: rtl/darkfetch_ctrl_if.sv
// darkfetch_ctrl_if: bundles the darkpc, instruction-bus, decode and redirect signals
// of the fetch sequencer. master = the sequencer, slave = its environment.
`timescale 1ns/1ps
interface darkfetch_ctrl_if;
    // darkpc side
    logic        pc_res;
    logic        pc_en;
    logic [31:0] pc_nxpc;
    logic [31:0] pc_in;
    logic        pc_valid;
    // instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    // decode side
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    // execute side
    logic        redir;
    logic [31:0] redir_pc;
    logic        halt;
    logic        misalign;

    modport master (
        output pc_res, pc_en, pc_nxpc, imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
        input  pc_in, pc_valid, imem_ack, imem_data, inst_ready, redir, redir_pc, halt
    );

    modport slave (
        input  pc_res, pc_en, pc_nxpc, imem_req, imem_addr, inst_valid, inst, inst_pc, misalign,
        output pc_in, pc_valid, imem_ack, imem_data, inst_ready, redir, redir_pc, halt
    );
endinterface

// File: rtl/darkfetch_ctrl.sv
// darkfetch_ctrl: fetch sequencer. Boots and steps darkpc, runs the single-outstanding
// instruction-memory request and buffers one instruction for decode.
// Optional feature macro: MISALIGN_TRAP_EN -- misaligned redirect targets trap to TRAP_VEC
// and pulse misalign; without it the target is silently word-aligned.
`timescale 1ns/1ps
module darkfetch_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0000
) (
    input logic              clk,
    input logic              res,
    darkfetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {StBoot, StStart, StIssue, StWpc, StWmem, StOut} state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, nxt_q, pend_pc_q, addr_q, inst_q, inst_pc_q;
    logic        pend_q, kill_q, req_q, ivalid_q, misalign_q;
    logic        redir_live, redir_bad, issue_go;
    logic [31:0] redir_tgt;
    logic        pc_res_c, pc_en_c;
    logic [31:0] pc_nxpc_c;

`ifdef MISALIGN_TRAP_EN
    assign redir_bad = |bus.redir_pc[1:0];
`else
    assign redir_bad = 1'b0;
`endif
    // When not trapping the low bits are cleared; with the trap enabled they are already zero.
    assign redir_tgt  = redir_bad ? TRAP_VEC : (bus.redir_pc & 32'hFFFF_FFFC);
    assign redir_live = bus.redir && (state_q != StBoot) && (state_q != StStart);

    // darkpc ignores en in its valid cycle, so never strobe it then.
    assign issue_go = ((state_q == StStart) || ((state_q == StIssue) && !bus.halt)) &&
                      !bus.pc_valid;

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state_q <= StBoot;
        else      state_q <= state_d;
    end

    // Next-state logic; a redirect seen with pc_valid or ack discards that result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:  state_d = StStart;
            StStart: if (issue_go) state_d = StWpc;
            StIssue: if (issue_go) state_d = StWpc;
            StWpc:   if (bus.pc_valid) state_d = (pend_q || bus.redir) ? StIssue : StWmem;
            StWmem:  if (bus.imem_ack) state_d = (kill_q || bus.redir) ? StIssue : StOut;
            StOut:   if (bus.redir || bus.inst_ready) state_d = StIssue;
            default: state_d = StBoot;
        endcase
    end

    // Combinational darkpc controls; a redirect in the issue cycle bypasses nxt.
    always_comb begin
        pc_res_c  = (state_q == StBoot);
        pc_en_c   = issue_go;
        pc_nxpc_c = ((state_q == StIssue) && bus.redir) ? redir_tgt : nxt_q;
    end

    // Fetch datapath: pc capture, memory request, instruction buffer, pending redirect.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            fpc_q      <= 32'h0;
            nxt_q      <= 32'h0;
            pend_pc_q  <= 32'h0;
            addr_q     <= 32'h0;
            inst_q     <= 32'h0;
            inst_pc_q  <= 32'h0;
            pend_q     <= 1'b0;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            ivalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redir_live && redir_bad;
            case (state_q)
                StIssue: begin
                    if (bus.redir) nxt_q <= redir_tgt;
                end
                StWpc: begin
                    if (bus.redir) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_tgt;
                    end
                    if (bus.pc_valid) begin
                        if (pend_q || bus.redir) begin
                            nxt_q  <= bus.redir ? redir_tgt : pend_pc_q;
                            pend_q <= 1'b0;
                        end else begin
                            fpc_q  <= bus.pc_in;
                            req_q  <= 1'b1;
                            addr_q <= bus.pc_in;
                        end
                    end
                end
                StWmem: begin
                    if (bus.redir) begin
                        pend_q    <= 1'b1;
                        pend_pc_q <= redir_tgt;
                        kill_q    <= 1'b1;
                    end
                    if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        if (kill_q || bus.redir) begin
                            nxt_q  <= bus.redir ? redir_tgt : pend_pc_q;
                            kill_q <= 1'b0;
                            pend_q <= 1'b0;
                        end else begin
                            inst_q    <= bus.imem_data;
                            inst_pc_q <= fpc_q;
                            ivalid_q  <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (bus.redir) begin
                        ivalid_q <= 1'b0;
                        nxt_q    <= redir_tgt;
                    end else if (bus.inst_ready) begin
                        ivalid_q <= 1'b0;
                        nxt_q    <= fpc_q + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_res     = pc_res_c;
    assign bus.pc_en      = pc_en_c;
    assign bus.pc_nxpc    = pc_nxpc_c;
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = ivalid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_darkfetch_ctrl.sv
// tb_darkfetch_ctrl: randomized bench with darkpc and imem models, and a scoreboard of the
// instruction addresses decode must see next.
`timescale 1ns/1ps
module tb_darkfetch_ctrl;
    localparam logic [31:0] TRAP     = 32'h0000_0080;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          NCYC     = 4000;

    logic clk = 1'b0;
    logic res = 1'b1;

    darkfetch_ctrl_if bus ();
    darkfetch_ctrl #(.TRAP_VEC(TRAP)) dut (.clk(clk), .res(res), .bus(bus));

    always #5 clk = ~clk;

    int          tests     = 0;
    int          fails     = 0;
    int          delivered = 0;
    int          cyc       = 0;
    int          ack_lo    = 1;
    int          ack_hi    = 1;
    logic [31:0] salt      = 32'h0;
    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt;
    endfunction

    // Where a redirect to p must land.
    function automatic logic [31:0] redir_target(input logic [31:0] p);
`ifdef MISALIGN_TRAP_EN
        return (p[1:0] != 2'b00) ? TRAP : p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
        end
    endtask

    // darkpc model: en sampled at an edge yields pc_valid for the following cycle.
    initial begin
        logic        en_s, rs_s, fresh;
        logic [31:0] nx_s;
        bus.pc_valid = 1'b0;
        bus.pc_in    = 32'h0;
        fresh        = 1'b1;
        forever begin
            @(negedge clk);
            en_s = bus.pc_en;
            nx_s = bus.pc_nxpc;
            rs_s = bus.pc_res;
            @(posedge clk);
            #1;
            bus.pc_valid = 1'b0;
            if (!res || rs_s) begin
                fresh = 1'b1;
            end else if (en_s) begin
                bus.pc_valid = 1'b1;
                bus.pc_in    = fresh ? RESET_PC : nx_s;
                fresh        = 1'b0;
            end
        end
    end

    // imem model: acks each request after a random wait, junk data when not acking.
    initial begin
        int cnt;
        bit busy;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
        cnt           = 0;
        busy          = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!res) begin
                bus.imem_ack = 1'b0;
                busy         = 1'b0;
            end else if (bus.imem_ack) begin
                bus.imem_ack  = 1'b0;
                bus.imem_data = $urandom;
                busy          = 1'b0;
            end else if (bus.imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = $urandom_range(ack_hi, ack_lo);
                end
                if (cnt == 0) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = mem_word(bus.imem_addr);
                end else begin
                    cnt--;
                    bus.imem_data = $urandom;
                end
            end
        end
    end

    // Monitor: scoreboard pops plus protocol checks, sampled mid-cycle.
    initial begin
        logic        p_hold, p_wait, p_valid, p_req, p_redir, p_bad, mis_exp;
        logic [31:0] p_inst, p_ipc, p_addr, e;
        p_hold = 0; p_wait = 0; p_valid = 0; p_req = 0; p_redir = 0; p_bad = 0;
        p_inst = 0; p_ipc = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            if (res) begin
                if (cyc == 1) begin
                    check(!bus.pc_res, "boot_pc_res_drop", 32'(bus.pc_res), 32'h0);
                    check(bus.pc_en, "start_pc_en", 32'(bus.pc_en), 32'h1);
                end
                if (bus.pc_valid)
                    check(!bus.pc_en, "pc_en_with_pc_valid", 32'(bus.pc_en), 32'h0);
                if (bus.halt)
                    check(!bus.pc_en, "halt_blocks_pc_en", 32'(bus.pc_en), 32'h0);
                if (bus.pc_en)
                    check(bus.pc_nxpc == exp_pc, "pc_nxpc", bus.pc_nxpc, exp_pc);
                if (bus.imem_req && !p_req && !bus.redir)
                    check(bus.imem_addr == exp_pc, "fetch_addr", bus.imem_addr, exp_pc);
                if (p_wait) begin
                    check(bus.imem_req, "req_held", 32'(bus.imem_req), 32'h1);
                    check(bus.imem_addr == p_addr, "addr_held", bus.imem_addr, p_addr);
                end
                if (p_hold) begin
                    check(bus.inst_valid, "valid_held", 32'(bus.inst_valid), 32'h1);
                    check(bus.inst == p_inst, "inst_held", bus.inst, p_inst);
                    check(bus.inst_pc == p_ipc, "inst_pc_held", bus.inst_pc, p_ipc);
                end
                if (bus.inst_valid && !p_valid && delivered < 4)
                    check(cyc == 5 * (delivered + 1), "fetch_latency", 32'(cyc),
                          32'(5 * (delivered + 1)));
`ifdef MISALIGN_TRAP_EN
                mis_exp = p_redir && p_bad;
`else
                mis_exp = 1'b0;
`endif
                check(bus.misalign == mis_exp, "misalign", 32'(bus.misalign), 32'(mis_exp));
                if (bus.inst_valid && (bus.inst_ready || bus.redir)) begin
                    check(exp_q.size() != 0, "unexpected_inst", bus.inst_pc, 32'h0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(bus.inst_pc == e, "inst_pc", bus.inst_pc, e);
                        check(bus.inst == mem_word(e), "inst_data", bus.inst, mem_word(e));
                    end
                    delivered++;
                end
            end
            p_hold  = bus.inst_valid && !bus.inst_ready && !bus.redir;
            p_wait  = bus.imem_req && !bus.imem_ack;
            p_valid = bus.inst_valid;
            p_req   = bus.imem_req;
            p_redir = bus.redir;
            p_bad   = (bus.redir_pc[1:0] != 2'b00);
            p_inst  = bus.inst;
            p_ipc   = bus.inst_pc;
            p_addr  = bus.imem_addr;
        end
    end

    // Stimulus and reference model: next expected address is the latest redirect target,
    // otherwise the last consumed address plus 4.
    initial begin
        logic        r, rdy, h, cons;
        logic [31:0] rp, tgt, e;
        bus.redir      = 1'b0;
        bus.redir_pc   = 32'h0;
        bus.halt       = 1'b0;
        bus.inst_ready = 1'b0;
        salt           = $urandom;

        #2 res = 1'b0;
        #2;
        check(bus.pc_res == 1'b1, "rst_pc_res", 32'(bus.pc_res), 32'h1);
        check(bus.pc_en == 1'b0, "rst_pc_en", 32'(bus.pc_en), 32'h0);
        check(bus.imem_req == 1'b0, "rst_imem_req", 32'(bus.imem_req), 32'h0);
        check(bus.inst_valid == 1'b0, "rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check(bus.misalign == 1'b0, "rst_misalign", 32'(bus.misalign), 32'h0);
        check(bus.imem_addr == 32'h0, "rst_imem_addr", bus.imem_addr, 32'h0);
        check(bus.inst_pc == 32'h0, "rst_inst_pc", bus.inst_pc, 32'h0);
        check(bus.pc_nxpc == 32'h0, "rst_pc_nxpc", bus.pc_nxpc, 32'h0);

        repeat (3) @(negedge clk);
        exp_q          = {RESET_PC};
        exp_pc         = RESET_PC;
        bus.inst_ready = 1'b1;
        #2 res = 1'b1;
        #1;
        check(bus.pc_res == 1'b1, "boot_pc_res", 32'(bus.pc_res), 32'h1);

        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            r   = 1'b0;
            rdy = 1'b1;
            h   = 1'b0;
            rp  = $urandom;
            if (delivered >= 4 && i < NCYC - 20) begin
                ack_lo = 0;
                ack_hi = 3;
                rdy    = ($urandom_range(9) < 6);
                h      = ($urandom_range(9) < 2);
                r      = ($urandom_range(15) == 0);
                case ($urandom_range(3))
                    0:       rp = $urandom & 32'h0000_0FFC;
                    1:       rp = $urandom & 32'h0000_0FFF;
                    2:       rp = 32'hFFFF_FFF8;
                    default: rp = 32'h0000_0102;
                endcase
            end
            cons = bus.inst_valid && (rdy || r);
            if (r) begin
                tgt = redir_target(rp);
                if (cons && exp_q.size() != 0) begin
                    e     = exp_q[0];
                    exp_q = {e, tgt};
                end else begin
                    exp_q = {tgt};
                end
                exp_pc = tgt;
            end else if (cons) begin
                exp_pc = exp_pc + 32'd4;
                exp_q.push_back(exp_pc);
            end
            bus.redir      = r;
            bus.redir_pc   = rp;
            bus.halt       = h;
            bus.inst_ready = rdy;
        end

        check(delivered > 100, "progress", 32'(delivered), 32'd101);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
